// File: rtl/fft_stage_sequencer.sv
// Address and strobe sequencer for an in-place radix-2 DIT FFT built around one shared butterfly.
// Each stage issues N/2 butterflies, then drains the read+butterfly pipeline before the next stage reads.
module fft_stage_sequencer #(
    parameter int N_POINTS     = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int BFLY_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(N_POINTS)-1:0]      stage,
    output logic                             rd_en,
    output logic [$clog2(N_POINTS)-1:0]      rd_addr0,
    output logic [$clog2(N_POINTS)-1:0]      rd_addr1,
    output logic [$clog2(N_POINTS)-2:0]      tw_addr,
    output logic                             wr_en,
    output logic [$clog2(N_POINTS)-1:0]      wr_addr0,
    output logic [$clog2(N_POINTS)-1:0]      wr_addr1
);

    localparam int LOG2N    = $clog2(N_POINTS);
    localparam int WB_DELAY = MEM_LATENCY + BFLY_LATENCY;
    localparam int BW       = LOG2N - 1;
    localparam int DW       = $clog2(WB_DELAY + 1);

    localparam logic [BW-1:0]    B_LAST     = BW'(N_POINTS / 2 - 1);
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(WB_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state_r, state_s;
    logic [LOG2N-1:0]            stage_s;
    logic [BW-1:0]               b_r, b_s;
    logic [DW-1:0]               drain_r, drain_s;
    logic [LOG2N-1:0]            a0_s, a1_s;
    logic [BW-1:0]               tw_s;

    logic [WB_DELAY-1:0]             dl_valid_r;
    logic [WB_DELAY-1:0][LOG2N-1:0]  dl_a0_r;
    logic [WB_DELAY-1:0][LOG2N-1:0]  dl_a1_r;

    // Upper-leg address: butterflies of a stage form groups of 2h, b indexes group then offset.
    function automatic logic [LOG2N-1:0] addr0_f(input logic [LOG2N-1:0] s, input logic [BW-1:0] b);
        logic [LOG2N-1:0] be;
        logic [LOG2N-1:0] mask;
        be   = {1'b0, b};
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        return ((be >> s) << (s + LOG2N'(1))) | (be & mask);
    endfunction

    function automatic logic [BW-1:0] tw_f(input logic [LOG2N-1:0] s, input logic [BW-1:0] b);
        logic [BW-1:0] mask;
        mask = BW'((LOG2N'(1) << s) - LOG2N'(1));
        return (b & mask) << (LOG2N'(BW) - s);
    endfunction

    // Next-state logic and the address/strobe values to be registered for the coming cycle.
    always_comb begin
        state_s = state_r;
        stage_s = stage;
        b_s     = b_r;
        drain_s = drain_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ISSUE;
                    stage_s = '0;
                    b_s     = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (b_r == B_LAST) begin
                    state_s = DRAIN;
                    drain_s = '0;
                end else begin
                    b_s = b_r + BW'(1);
                end
            end
            DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    if (stage < STAGE_LAST) begin
                        state_s = ISSUE;
                        stage_s = stage + LOG2N'(1);
                        b_s     = '0;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    drain_s = drain_r + DW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        a0_s = addr0_f(stage_s, b_s);
        a1_s = a0_s + (LOG2N'(1) << stage_s);
        tw_s = tw_f(stage_s, b_s);
    end

    // State, counters and registered read-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            stage    <= '0;
            b_r      <= '0;
            drain_r  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
        end else begin
            state_r <= state_s;
            stage   <= stage_s;
            b_r     <= b_s;
            drain_r <= drain_s;
            busy    <= (state_s != IDLE);
            done    <= (state_s == DONE);
            rd_en   <= (state_s == ISSUE);
            if (state_s == ISSUE) begin
                rd_addr0 <= a0_s;
                rd_addr1 <= a1_s;
                tw_addr  <= tw_s;
            end else begin
                rd_addr0 <= '0;
                rd_addr1 <= '0;
                tw_addr  <= '0;
            end
        end
    end

    // Write-back delay line; its last tap drives the write port, so a reset flushes in-flight writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid_r <= '0;
            dl_a0_r    <= '0;
            dl_a1_r    <= '0;
        end else begin
            dl_valid_r[0] <= rd_en;
            dl_a0_r[0]    <= rd_addr0;
            dl_a1_r[0]    <= rd_addr1;
            for (int i = 1; i < WB_DELAY; i++) begin
                dl_valid_r[i] <= dl_valid_r[i-1];
                dl_a0_r[i]    <= dl_a0_r[i-1];
                dl_a1_r[i]    <= dl_a1_r[i-1];
            end
        end
    end

    assign wr_en    = dl_valid_r[WB_DELAY-1];
    assign wr_addr0 = dl_a0_r[WB_DELAY-1];
    assign wr_addr1 = dl_a1_r[WB_DELAY-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: address scoreboard, RAM model running a real FFT, reset cases.
module tb_fft_stage_sequencer;

    localparam int    N     = 16;
    localparam int    LG    = 4;
    localparam int    WB    = 3;
    localparam int    PER   = N / 2 + WB;
    localparam int    DONEC = LG * PER + 1;
    localparam real   PI    = 3.14159265358979323846;

    typedef struct {
        int cyc;
        int st;
        int a0;
        int a1;
        int tw;
    } rd_rec_t;

    typedef struct {
        int  cyc;
        int  a0;
        int  a1;
        real y0r;
        real y0i;
        real y1r;
        real y1i;
    } wr_rec_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic [LG-1:0]   stage;
    logic            rd_en;
    logic [LG-1:0]   rd_addr0;
    logic [LG-1:0]   rd_addr1;
    logic [LG-2:0]   tw_addr;
    logic            wr_en;
    logic [LG-1:0]   wr_addr0;
    logic [LG-1:0]   wr_addr1;

    int      n_checks;
    int      n_pass;
    int      cyc;
    int      t0;
    bit      pass_active;
    rd_rec_t rdq[$];
    wr_rec_t wrq[$];
    real     ram_re[N];
    real     ram_im[N];
    real     gold_re[N];
    real     gold_im[N];

    fft_stage_sequencer #(
        .N_POINTS    (N),
        .MEM_LATENCY (1),
        .BFLY_LATENCY(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .stage   (stage),
        .rd_en   (rd_en),
        .rd_addr0(rd_addr0),
        .rd_addr1(rd_addr1),
        .tw_addr (tw_addr),
        .wr_en   (wr_en),
        .wr_addr0(wr_addr0),
        .wr_addr1(wr_addr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LG; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Current cycle becomes cycle 0 of a pass: expected issue schedule, fresh input, golden DFT.
    task automatic setup_pass();
        real xr[N];
        real xi[N];
        rd_rec_t r;
        int b;
        t0 = cyc;
        rdq.delete();
        wrq.delete();
        for (int s = 0; s < LG; s++) begin
            int h;
            h = 1 << s;
            b = 0;
            for (int g = 0; g < N; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    r.cyc = 1 + s * PER + b;
                    r.st  = s;
                    r.a0  = g + j;
                    r.a1  = g + j + h;
                    r.tw  = j * (N / (2 * h));
                    rdq.push_back(r);
                    b++;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            xr[k] = real'($urandom_range(200)) - 100.0;
            xi[k] = real'($urandom_range(200)) - 100.0;
        end
        for (int k = 0; k < N; k++) begin
            ram_re[bitrev(k)] = xr[k];
            ram_im[bitrev(k)] = xi[k];
            gold_re[k] = 0.0;
            gold_im[k] = 0.0;
            for (int n = 0; n < N; n++) begin
                real a;
                a = 2.0 * PI * real'((n * k) % N) / real'(N);
                gold_re[k] += xr[n] * $cos(a) + xi[n] * $sin(a);
                gold_im[k] += xi[n] * $cos(a) - xr[n] * $sin(a);
            end
        end
        pass_active = 1'b1;
    endtask

    task automatic wait_pass_end();
        do begin
            @(negedge clk);
            #1;
        end while (cyc - t0 < DONEC + 1);
        chk("rd_left", rdq.size(), 0);
        chk("wr_left", wrq.size(), 0);
    endtask

    task automatic fft_check();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("fft_bin%0d", k),
                (rabs(ram_re[k] - gold_re[k]) < 1e-6) && (rabs(ram_im[k] - gold_im[k]) < 1e-6), 1);
        end
        pass_active = 1'b0;
    endtask

    // Scoreboard monitor: pops expected issues, models the RAM and butterfly, retires write-backs.
    always @(negedge clk) begin
        int      rel;
        rd_rec_t e;
        wr_rec_t w;
        bit      hit;
        real     wr_, wi_, x0r, x0i, x1r, x1i, tr, ti, ang;
        rel = cyc - t0;
        if (rd_en === 1'b1) begin
            chk("rd_expected", rdq.size() > 0, 1);
            if (rdq.size() > 0) begin
                e = rdq.pop_front();
                chk("rd_cycle", rel, e.cyc);
                chk("rd_stage", stage, e.st);
                chk("rd_addr0", rd_addr0, e.a0);
                chk("rd_addr1", rd_addr1, e.a1);
                chk("tw_addr", tw_addr, e.tw);
                hit = 1'b0;
                foreach (wrq[i]) begin
                    if (wrq[i].a0 == int'(rd_addr0) || wrq[i].a1 == int'(rd_addr0) ||
                        wrq[i].a0 == int'(rd_addr1) || wrq[i].a1 == int'(rd_addr1)) hit = 1'b1;
                end
                chk("rw_hazard", hit, 0);
                ang = 2.0 * PI * real'(tw_addr) / real'(N);
                wr_ = $cos(ang);
                wi_ = -$sin(ang);
                x0r = ram_re[rd_addr0];
                x0i = ram_im[rd_addr0];
                x1r = ram_re[rd_addr1];
                x1i = ram_im[rd_addr1];
                tr  = wr_ * x1r - wi_ * x1i;
                ti  = wr_ * x1i + wi_ * x1r;
                w.cyc = e.cyc + WB;
                w.a0  = e.a0;
                w.a1  = e.a1;
                w.y0r = x0r + tr;
                w.y0i = x0i + ti;
                w.y1r = x0r - tr;
                w.y1i = x0i - ti;
                wrq.push_back(w);
            end
        end
        if (wr_en === 1'b1) begin
            chk("wr_expected", wrq.size() > 0, 1);
            if (wrq.size() > 0) begin
                w = wrq.pop_front();
                chk("wr_cycle", rel, w.cyc);
                chk("wr_addr0", wr_addr0, w.a0);
                chk("wr_addr1", wr_addr1, w.a1);
                ram_re[wr_addr0] = w.y0r;
                ram_im[wr_addr0] = w.y0i;
                ram_re[wr_addr1] = w.y1r;
                ram_im[wr_addr1] = w.y1i;
            end
        end
        if (pass_active) begin
            chk("busy", busy, (rel >= 1) && (rel <= DONEC));
            chk("done", done, rel == DONEC);
        end
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        cyc         = 0;
        t0          = 0;
        pass_active = 1'b0;
        rst         = 1'b1;
        start       = 1'b1;

        // Reset held with start high: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_wr_en", wr_en, 0);
        end
        chk("rst_done", done, 0);
        chk("rst_stage", stage, 0);
        chk("rst_rd_addr0", rd_addr0, 0);
        chk("rst_rd_addr1", rd_addr1, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_wr_addr0", wr_addr0, 0);
        chk("rst_wr_addr1", wr_addr1, 0);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rd_en", rd_en, 0);

        // Single start pulse, full pass.
        #1;
        setup_pass();
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_pass_end();
        fft_check();

        // Start held high: second pass begins at cycle 47 of the first.
        setup_pass();
        start = 1'b1;
        wait_pass_end();
        setup_pass();
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_pass_end();
        fft_check();

        // Reset in the middle of stage 1.
        setup_pass();
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        while (cyc - t0 < 20) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        rdq.delete();
        wrq.delete();
        pass_active = 1'b0;
        @(negedge clk);
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_stage", stage, 0);
        chk("midrst_done", done, 0);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;

        // Clean pass after the aborted one.
        setup_pass();
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_pass_end();
        fft_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
